// File: rtl/mod_feeder.sv
// -----------------------------------------------------------------------------
// mod_feeder
//
// Feeds a streaming processing engine: accepts a job descriptor, buffers an
// inbound source stream in a first-word-fall-through FIFO that the engine reads,
// collects engine results in a destination FIFO drained to an outbound stream,
// and sequences the engine through reset, run and drain phases.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   job_valid/job_ready/job_dc job handshake and 24-bit descriptor control word
//   ss_data/ss_last/ss_valid/ss_ready  source stream in
//   ds_data/ds_last/ds_valid/ds_ready  result stream out
//   m_reset/m_enable/dc       engine control (dc = latched descriptor)
//   m_src*/m_src_getn         engine-side source FIFO read port (active-low get)
//   m_dst*/m_dst_putn         engine-side destination FIFO write port (active-low put)
//   m_endn                    engine end-of-job, active-low
//   busy/done/err_ovf/err_unf status (errors are sticky until next job accept)
// -----------------------------------------------------------------------------
module mod_feeder #(
  parameter int DEPTH  = 16,
  parameter int AE_LVL = 2,
  parameter int AF_LVL = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_dc,
  input  logic [63:0] ss_data,
  input  logic        ss_last,
  input  logic        ss_valid,
  output logic        ss_ready,
  output logic [63:0] ds_data,
  output logic        ds_last,
  output logic        ds_valid,
  input  logic        ds_ready,
  output logic        m_reset,
  output logic        m_enable,
  output logic [23:0] dc,
  output logic [63:0] m_src,
  output logic        m_src_last,
  output logic        m_src_almost_empty,
  output logic        m_src_empty,
  input  logic        m_src_getn,
  input  logic [63:0] m_dst,
  input  logic        m_dst_last,
  output logic        m_dst_almost_full,
  output logic        m_dst_full,
  input  logic        m_dst_putn,
  input  logic        m_endn,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LVL);
  // almost-full is "free entries <= AF_LVL", i.e. count >= DEPTH - AF_LVL
  localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - AF_LVL);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          rst_cnt_r;
  logic          rst_state_s;
  logic          job_acc_s;

  logic [23:0]   dc_r;
  logic          last_taken_r;
  logic          err_ovf_r;
  logic          err_unf_r;

  // source FIFO
  logic [64:0]   src_mem_r [DEPTH];
  logic [AW-1:0] src_wr_ptr_r;
  logic [AW-1:0] src_rd_ptr_r;
  logic [CW-1:0] src_cnt_r;
  logic [CW-1:0] src_cnt_nxt_s;
  logic          src_empty_r;
  logic          src_full_r;
  logic          src_ae_r;
  logic          src_push_s;
  logic          src_pop_s;
  logic          unf_s;
  logic [64:0]   src_head_s;

  // destination FIFO
  logic [64:0]   dst_mem_r [DEPTH];
  logic [AW-1:0] dst_wr_ptr_r;
  logic [AW-1:0] dst_rd_ptr_r;
  logic [CW-1:0] dst_cnt_r;
  logic [CW-1:0] dst_cnt_nxt_s;
  logic          dst_empty_r;
  logic          dst_full_r;
  logic          dst_af_r;
  logic          dst_push_s;
  logic          dst_pop_s;
  logic          ovf_s;
  logic [64:0]   dst_head_s;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register plus the one-bit counter that times the two RST cycles
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= ST_IDLE;
      rst_cnt_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rst_cnt_r <= (state_r == ST_RST) ? ~rst_cnt_r : 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (job_valid) state_nxt_s = ST_RST;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RST: begin
        if (rst_cnt_r) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_RST;
      end
      ST_RUN: begin
        if (!m_endn) state_nxt_s = ST_DRAIN;
        else         state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        // a put in this cycle would make the FIFO non-empty again
        if (dst_empty_r && m_dst_putn) state_nxt_s = ST_DONE;
        else                           state_nxt_s = ST_DRAIN;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs; forced inactive while system reset is asserted
  always_comb begin
    job_ready   = 1'b0;
    m_enable    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    rst_state_s = 1'b0;
    ss_ready    = 1'b0;
    if (!wb_rst_i) begin
      case (state_r)
        ST_IDLE:  job_ready = 1'b1;
        ST_RST: begin
          rst_state_s = 1'b1;
          busy        = 1'b1;
        end
        ST_RUN: begin
          m_enable = 1'b1;
          busy     = 1'b1;
          // uses the pre-pop full flag: a full FIFO takes no push in a pop cycle
          ss_ready = ~src_full_r & ~last_taken_r;
        end
        ST_DRAIN: busy = 1'b1;
        ST_DONE:  done = 1'b1;
        default:  job_ready = 1'b0;
      endcase
    end else begin
      job_ready   = 1'b0;
      rst_state_s = 1'b0;
    end
  end

  assign m_reset   = wb_rst_i | rst_state_s;
  assign job_acc_s = job_ready & job_valid;

  // ---------------------------------------------------------------------------
  // Job control and sticky status
  // ---------------------------------------------------------------------------

  // Descriptor latch, end-of-input tracking and sticky error flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dc_r         <= 24'd0;
      last_taken_r <= 1'b0;
      err_ovf_r    <= 1'b0;
      err_unf_r    <= 1'b0;
    end else if (job_acc_s) begin
      dc_r         <= job_dc;
      last_taken_r <= 1'b0;
      err_ovf_r    <= 1'b0;
      err_unf_r    <= 1'b0;
    end else begin
      if (src_push_s && ss_last) last_taken_r <= 1'b1;
      if (ovf_s)                 err_ovf_r    <= 1'b1;
      if (unf_s)                 err_unf_r    <= 1'b1;
    end
  end

  assign dc      = dc_r;
  assign err_ovf = err_ovf_r;
  assign err_unf = err_unf_r;

  // ---------------------------------------------------------------------------
  // Source FIFO (first-word-fall-through, engine-side reads)
  // ---------------------------------------------------------------------------

  // Gets are ignored while draining so a stalled engine cannot flag underflow
  assign src_push_s = ss_valid & ss_ready;
  assign src_pop_s  = ~m_src_getn & ~src_empty_r & (state_r != ST_DRAIN);
  assign unf_s      = ~m_src_getn &  src_empty_r & (state_r != ST_DRAIN);

  // Next source occupancy; job accept discards whatever the last job left
  always_comb begin
    src_cnt_nxt_s = src_cnt_r;
    if (job_acc_s) begin
      src_cnt_nxt_s = '0;
    end else begin
      case ({src_push_s, src_pop_s})
        2'b10:   src_cnt_nxt_s = src_cnt_r + CNT_ONE;
        2'b01:   src_cnt_nxt_s = src_cnt_r - CNT_ONE;
        default: src_cnt_nxt_s = src_cnt_r;
      endcase
    end
  end

  // Source pointers, count and flags registered from the next count
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      src_wr_ptr_r <= '0;
      src_rd_ptr_r <= '0;
      src_cnt_r    <= '0;
      src_empty_r  <= 1'b1;
      src_full_r   <= 1'b0;
      src_ae_r     <= 1'b1;
    end else begin
      if (job_acc_s) begin
        src_wr_ptr_r <= '0;
        src_rd_ptr_r <= '0;
      end else begin
        if (src_push_s) src_wr_ptr_r <= src_wr_ptr_r + PTR_ONE;
        if (src_pop_s)  src_rd_ptr_r <= src_rd_ptr_r + PTR_ONE;
      end
      src_cnt_r   <= src_cnt_nxt_s;
      src_empty_r <= (src_cnt_nxt_s == '0);
      src_full_r  <= (src_cnt_nxt_s == CNT_FULL);
      src_ae_r    <= (src_cnt_nxt_s <= CNT_AE);
    end
  end

  // Source storage
  always_ff @(posedge wb_clk_i) begin
    if (src_push_s) src_mem_r[src_wr_ptr_r] <= {ss_last, ss_data};
  end

  assign src_head_s         = src_mem_r[src_rd_ptr_r];
  assign m_src              = src_head_s[63:0];
  assign m_src_last         = src_head_s[64];
  assign m_src_empty        = src_empty_r;
  assign m_src_almost_empty = src_ae_r;

  // ---------------------------------------------------------------------------
  // Destination FIFO (engine-side writes, stream-side reads)
  // ---------------------------------------------------------------------------

  assign dst_push_s = ~m_dst_putn & ~dst_full_r;
  assign ovf_s      = ~m_dst_putn &  dst_full_r;
  assign dst_pop_s  = ~dst_empty_r & ds_ready;

  // Next destination occupancy
  always_comb begin
    dst_cnt_nxt_s = dst_cnt_r;
    if (job_acc_s) begin
      dst_cnt_nxt_s = '0;
    end else begin
      case ({dst_push_s, dst_pop_s})
        2'b10:   dst_cnt_nxt_s = dst_cnt_r + CNT_ONE;
        2'b01:   dst_cnt_nxt_s = dst_cnt_r - CNT_ONE;
        default: dst_cnt_nxt_s = dst_cnt_r;
      endcase
    end
  end

  // Destination pointers, count and flags registered from the next count
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dst_wr_ptr_r <= '0;
      dst_rd_ptr_r <= '0;
      dst_cnt_r    <= '0;
      dst_empty_r  <= 1'b1;
      dst_full_r   <= 1'b0;
      dst_af_r     <= 1'b0;
    end else begin
      if (job_acc_s) begin
        dst_wr_ptr_r <= '0;
        dst_rd_ptr_r <= '0;
      end else begin
        if (dst_push_s) dst_wr_ptr_r <= dst_wr_ptr_r + PTR_ONE;
        if (dst_pop_s)  dst_rd_ptr_r <= dst_rd_ptr_r + PTR_ONE;
      end
      dst_cnt_r   <= dst_cnt_nxt_s;
      dst_empty_r <= (dst_cnt_nxt_s == '0);
      dst_full_r  <= (dst_cnt_nxt_s == CNT_FULL);
      dst_af_r    <= (dst_cnt_nxt_s >= CNT_AF);
    end
  end

  // Destination storage
  always_ff @(posedge wb_clk_i) begin
    if (dst_push_s) dst_mem_r[dst_wr_ptr_r] <= {m_dst_last, m_dst};
  end

  assign dst_head_s        = dst_mem_r[dst_rd_ptr_r];
  assign ds_data           = dst_head_s[63:0];
  assign ds_last           = dst_head_s[64];
  assign ds_valid          = ~dst_empty_r;
  assign m_dst_full        = dst_full_r;
  assign m_dst_almost_full = dst_af_r;

endmodule

// File: tb/tb_mod_feeder.sv
module tb_mod_feeder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_dc;
  logic [63:0] ss_data;
  logic        ss_last;
  logic        ss_valid;
  logic        ss_ready;
  logic [63:0] ds_data;
  logic        ds_last;
  logic        ds_valid;
  logic        ds_ready;
  logic        m_reset;
  logic        m_enable;
  logic [23:0] dc;
  logic [63:0] m_src;
  logic        m_src_last;
  logic        m_src_almost_empty;
  logic        m_src_empty;
  logic        m_src_getn;
  logic [63:0] m_dst;
  logic        m_dst_last;
  logic        m_dst_almost_full;
  logic        m_dst_full;
  logic        m_dst_putn;
  logic        m_endn;
  logic        busy;
  logic        done;
  logic        err_ovf;
  logic        err_unf;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  mod_feeder #(.DEPTH(16), .AE_LVL(2), .AF_LVL(2)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .job_valid(job_valid), .job_ready(job_ready), .job_dc(job_dc),
    .ss_data(ss_data), .ss_last(ss_last), .ss_valid(ss_valid), .ss_ready(ss_ready),
    .ds_data(ds_data), .ds_last(ds_last), .ds_valid(ds_valid), .ds_ready(ds_ready),
    .m_reset(m_reset), .m_enable(m_enable), .dc(dc),
    .m_src(m_src), .m_src_last(m_src_last), .m_src_almost_empty(m_src_almost_empty),
    .m_src_empty(m_src_empty), .m_src_getn(m_src_getn),
    .m_dst(m_dst), .m_dst_last(m_dst_last), .m_dst_almost_full(m_dst_almost_full),
    .m_dst_full(m_dst_full), .m_dst_putn(m_dst_putn),
    .m_endn(m_endn),
    .busy(busy), .done(done), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // counts done pulses seen at active edges
  always @(posedge wb_clk_i) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_job(input logic [23:0] d);
    job_dc    = d;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  // end the job and wait (bounded) for the done pulse, then return to IDLE
  task automatic finish_job(output bit seen);
    seen   = 1'b0;
    m_endn = 1'b0;
    tick();
    m_endn   = 1'b1;
    ds_ready = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    ds_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; job_valid = 1'b0; job_dc = 24'd0;
    ss_data = 64'd0; ss_last = 1'b0; ss_valid = 1'b0; ds_ready = 1'b0;
    m_src_getn = 1'b1; m_dst = 64'd0; m_dst_last = 1'b0; m_dst_putn = 1'b1; m_endn = 1'b1;
    tick(); tick();
    checks++; if ({m_enable, busy, done, ss_ready, ds_valid, m_src_empty, m_src_almost_empty,
                   m_dst_full, m_dst_almost_full, m_reset} !== 10'b0000011001) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", {m_enable, busy, done, ss_ready,
        ds_valid, m_src_empty, m_src_almost_empty, m_dst_full, m_dst_almost_full, m_reset}, 10'b0000011001);
    end
    wb_rst_i = 1'b0;
    #1;
    checks++; if ({m_reset, job_ready, err_ovf, err_unf} !== 4'b0100) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", {m_reset, job_ready, err_ovf, err_unf}, 4'b0100);
    end
    checks++; if (dc !== 24'd0) begin errors++; $display("FAIL reset_dc got=%h exp=%h", dc, 24'd0); end
  endtask

  task automatic test_nominal();
    logic [64:0] exp;
    start_job(24'h000010);
    checks++; if ({m_reset, m_enable, busy, job_ready} !== 4'b1010) begin
      errors++; $display("FAIL nom_rst1 got=%b exp=%b", {m_reset, m_enable, busy, job_ready}, 4'b1010);
    end
    checks++; if (dc !== 24'h000010) begin errors++; $display("FAIL nom_dc got=%h exp=%h", dc, 24'h000010); end
    tick();
    checks++; if ({m_reset, m_enable} !== 2'b10) begin
      errors++; $display("FAIL nom_rst2 got=%b exp=%b", {m_reset, m_enable}, 2'b10);
    end
    tick();
    checks++; if ({m_reset, m_enable, ss_ready} !== 3'b011) begin
      errors++; $display("FAIL nom_run got=%b exp=%b", {m_reset, m_enable, ss_ready}, 3'b011);
    end
    for (int i = 0; i < 4; i++) begin
      ss_valid = 1'b1; ss_data = 64'h00A0 + 64'(i); ss_last = (i == 3);
      tick();
    end
    ss_valid = 1'b0; ss_last = 1'b0;
    checks++; if ({ss_ready, m_src_empty, m_src_almost_empty} !== 3'b000) begin
      errors++; $display("FAIL nom_src4 got=%b exp=%b", {ss_ready, m_src_empty, m_src_almost_empty}, 3'b000);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {(i == 3) ? 1'b1 : 1'b0, 64'h00A0 + 64'(i)};
      checks++; if ({m_src_last, m_src} !== exp) begin
        errors++; $display("FAIL nom_src_head%0d got=%h exp=%h", i, {m_src_last, m_src}, exp);
      end
      m_src_getn = 1'b0;
      tick();
    end
    m_src_getn = 1'b1;
    checks++; if ({m_src_empty, err_unf} !== 2'b10) begin
      errors++; $display("FAIL nom_src_drained got=%b exp=%b", {m_src_empty, err_unf}, 2'b10);
    end
    m_dst = 64'hBEEF; m_dst_last = 1'b1; m_dst_putn = 1'b0;
    tick();
    m_dst_putn = 1'b1; m_dst_last = 1'b0;
    checks++; if ({ds_valid, ds_last, ds_data} !== {1'b1, 1'b1, 64'hBEEF}) begin
      errors++; $display("FAIL nom_ds got=%h exp=%h", {ds_valid, ds_last, ds_data}, {1'b1, 1'b1, 64'hBEEF});
    end
    m_endn = 1'b0;
    tick();
    m_endn = 1'b1;
    checks++; if ({m_enable, busy, done} !== 3'b010) begin
      errors++; $display("FAIL nom_drain got=%b exp=%b", {m_enable, busy, done}, 3'b010);
    end
    ds_ready = 1'b1;
    tick();
    ds_ready = 1'b0;
    checks++; if ({ds_valid, done, busy} !== 3'b001) begin
      errors++; $display("FAIL nom_popped got=%b exp=%b", {ds_valid, done, busy}, 3'b001);
    end
    tick();
    checks++; if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL nom_done got=%b exp=%b", {done, busy}, 2'b10);
    end
    tick();
    checks++; if ({done, busy, job_ready} !== 3'b001) begin
      errors++; $display("FAIL nom_idle got=%b exp=%b", {done, busy, job_ready}, 3'b001);
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL nom_done_count got=%0d exp=%0d", done_cnt, 1); end
    checks++; if (dc !== 24'h000010) begin errors++; $display("FAIL nom_dc_hold got=%h exp=%h", dc, 24'h000010); end
  endtask

  task automatic test_src_full();
    int acc;
    bit seen;
    logic [63:0] exp;
    acc = 0;
    start_job(24'h000111); tick(); tick();
    for (int i = 0; i < 20; i++) begin
      ss_valid = 1'b1; ss_data = 64'(i); ss_last = 1'b0;
      if (ss_ready === 1'b1) acc++;
      tick();
      if (i == 1) begin
        checks++; if (m_src_almost_empty !== 1'b1) begin
          errors++; $display("FAIL full_ae_cnt2 got=%b exp=%b", m_src_almost_empty, 1'b1);
        end
      end
      if (i == 2) begin
        checks++; if (m_src_almost_empty !== 1'b0) begin
          errors++; $display("FAIL full_ae_cnt3 got=%b exp=%b", m_src_almost_empty, 1'b0);
        end
      end
    end
    ss_data = 64'd20;
    checks++; if (acc !== 16) begin errors++; $display("FAIL full_accepted got=%0d exp=%0d", acc, 16); end
    checks++; if (ss_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=%b", ss_ready, 1'b0); end
    m_src_getn = 1'b0;
    tick();
    m_src_getn = 1'b1;
    checks++; if ({ss_ready, m_src} !== {1'b1, 64'd1}) begin
      errors++; $display("FAIL full_after_pop got=%h exp=%h", {ss_ready, m_src}, {1'b1, 64'd1});
    end
    tick();
    ss_valid = 1'b0;
    checks++; if (ss_ready !== 1'b0) begin errors++; $display("FAIL full_refill got=%b exp=%b", ss_ready, 1'b0); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 64'(i + 1) : 64'd20;
      checks++; if (m_src !== exp) begin errors++; $display("FAIL full_order%0d got=%h exp=%h", i, m_src, exp); end
      m_src_getn = 1'b0;
      tick();
    end
    m_src_getn = 1'b1;
    checks++; if (m_src_empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=%b", m_src_empty, 1'b1); end
    finish_job(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_done_timeout got=%b exp=%b", seen, 1'b1); end
  endtask

  task automatic test_underflow();
    bit seen;
    start_job(24'h000222); tick(); tick();
    checks++; if (err_unf !== 1'b0) begin errors++; $display("FAIL unf_pre got=%b exp=%b", err_unf, 1'b0); end
    m_src_getn = 1'b0;
    tick(); tick();
    m_src_getn = 1'b1;
    checks++; if ({err_unf, m_src_empty, m_src_almost_empty} !== 3'b111) begin
      errors++; $display("FAIL unf_flags got=%b exp=%b", {err_unf, m_src_empty, m_src_almost_empty}, 3'b111);
    end
    ss_valid = 1'b1; ss_data = 64'h5A5A; ss_last = 1'b0;
    tick();
    ss_valid = 1'b0;
    checks++; if ({m_src_empty, m_src} !== {1'b0, 64'h5A5A}) begin
      errors++; $display("FAIL unf_one_word got=%h exp=%h", {m_src_empty, m_src}, {1'b0, 64'h5A5A});
    end
    m_src_getn = 1'b0;
    tick();
    m_src_getn = 1'b1;
    checks++; if (m_src_empty !== 1'b1) begin errors++; $display("FAIL unf_count_zero got=%b exp=%b", m_src_empty, 1'b1); end
    finish_job(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL unf_done_timeout got=%b exp=%b", seen, 1'b1); end
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    start_job(24'h000333);
    checks++; if ({err_unf, err_ovf} !== 2'b00) begin
      errors++; $display("FAIL ovf_err_clear got=%b exp=%b", {err_unf, err_ovf}, 2'b00);
    end
    tick(); tick();
    ds_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      m_dst = 64'hD00 + 64'(i); m_dst_last = (i == 16); m_dst_putn = 1'b0;
      tick();
      if (i == 12) begin
        checks++; if (m_dst_almost_full !== 1'b0) begin errors++; $display("FAIL ovf_af13 got=%b exp=%b", m_dst_almost_full, 1'b0); end
      end
      if (i == 13) begin
        checks++; if (m_dst_almost_full !== 1'b1) begin errors++; $display("FAIL ovf_af14 got=%b exp=%b", m_dst_almost_full, 1'b1); end
      end
      if (i == 14) begin
        checks++; if (m_dst_full !== 1'b0) begin errors++; $display("FAIL ovf_full15 got=%b exp=%b", m_dst_full, 1'b0); end
      end
      if (i == 15) begin
        checks++; if ({m_dst_full, err_ovf} !== 2'b10) begin errors++; $display("FAIL ovf_full16 got=%b exp=%b", {m_dst_full, err_ovf}, 2'b10); end
      end
      if (i == 16) begin
        checks++; if ({m_dst_full, err_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_err got=%b exp=%b", {m_dst_full, err_ovf}, 2'b11); end
      end
    end
    m_dst_putn = 1'b1; m_dst_last = 1'b0;
    m_endn = 1'b0;
    tick();
    m_endn = 1'b1;
    m_src_getn = 1'b0;
    tick(); tick();
    m_src_getn = 1'b1;
    checks++; if ({m_enable, busy, done, err_unf} !== 4'b0100) begin
      errors++; $display("FAIL ovf_drain_hold got=%b exp=%b", {m_enable, busy, done, err_unf}, 4'b0100);
    end
    ds_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = 64'hD00 + 64'(i);
      checks++; if ({ds_valid, ds_last, ds_data} !== {1'b1, 1'b0, exp}) begin
        errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, {ds_valid, ds_last, ds_data}, {1'b1, 1'b0, exp});
      end
      tick();
    end
    checks++; if ({ds_valid, done} !== 2'b00) begin errors++; $display("FAIL ovf_empty got=%b exp=%b", {ds_valid, done}, 2'b00); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_done got=%b exp=%b", done, 1'b1); end
    tick();
    ds_ready = 1'b0;
    checks++; if ({done, job_ready} !== 2'b01) begin errors++; $display("FAIL ovf_idle got=%b exp=%b", {done, job_ready}, 2'b01); end
  endtask

  task automatic test_reset_mid();
    int cnt0;
    start_job(24'h000444); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      ss_valid = 1'b1; ss_data = 64'h700 + 64'(i); ss_last = 1'b0;
      tick();
    end
    ss_valid = 1'b0;
    checks++; if ({m_src_empty, m_enable} !== 2'b01) begin
      errors++; $display("FAIL rstm_pre got=%b exp=%b", {m_src_empty, m_enable}, 2'b01);
    end
    cnt0 = done_cnt;
    wb_rst_i = 1'b1;
    #1;
    checks++; if ({m_reset, m_enable} !== 2'b10) begin
      errors++; $display("FAIL rstm_during got=%b exp=%b", {m_reset, m_enable}, 2'b10);
    end
    tick();
    wb_rst_i = 1'b0;
    #1;
    checks++; if ({m_src_empty, m_enable, busy, job_ready, ss_ready, m_reset} !== 6'b100100) begin
      errors++; $display("FAIL rstm_after got=%b exp=%b", {m_src_empty, m_enable, busy, job_ready, ss_ready, m_reset}, 6'b100100);
    end
    tick(); tick(); tick();
    checks++; if (done_cnt !== cnt0) begin errors++; $display("FAIL rstm_no_done got=%0d exp=%0d", done_cnt, cnt0); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    m_endn = 1'b0;
    tick(); tick();
    m_endn = 1'b1;
    checks++; if ({job_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL b2b_endn_idle got=%b exp=%b", {job_ready, busy}, 2'b10);
    end
    start_job(24'hABCDEF); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      ss_valid = 1'b1; ss_data = 64'h900 + 64'(i); ss_last = (i == 2);
      tick();
    end
    ss_valid = 1'b0; ss_last = 1'b0;
    checks++; if ({ss_ready, m_src_empty} !== 2'b00) begin
      errors++; $display("FAIL b2b_last_taken got=%b exp=%b", {ss_ready, m_src_empty}, 2'b00);
    end
    finish_job(seen);
    checks++; if ({seen, dc} !== {1'b1, 24'hABCDEF}) begin
      errors++; $display("FAIL b2b_job1 got=%h exp=%h", {seen, dc}, {1'b1, 24'hABCDEF});
    end
    start_job(24'h123456);
    checks++; if ({m_src_empty, dc} !== {1'b1, 24'h123456}) begin
      errors++; $display("FAIL b2b_discard got=%h exp=%h", {m_src_empty, dc}, {1'b1, 24'h123456});
    end
    tick(); tick();
    checks++; if (ss_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=%b", ss_ready, 1'b1); end
    finish_job(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_done_timeout got=%b exp=%b", seen, 1'b1); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_src_full();
    test_underflow();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mod_feeder.md
MOD_FEEDER -- requirements
Module: mod_feeder

Interface
- REQ-001: Parameters SHALL be:
  - DEPTH, default 16: source and destination FIFO depth in 65-bit entries, power of two, at least 4.
  - AE_LVL, default 2: m_src_almost_empty asserts when source count <= AE_LVL.
  - AF_LVL, default 2: m_dst_almost_full asserts when destination free entries <= AF_LVL.
- REQ-002: The module SHALL have one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- REQ-003: Ports SHALL be, in order (name, direction, width, meaning):
  - wb_clk_i in 1: clock.
  - wb_rst_i in 1: synchronous active-high reset.
  - job_valid in 1 / job_ready out 1 / job_dc in 24: job handshake and descriptor control word.
  - ss_data in 64 / ss_last in 1 / ss_valid in 1 / ss_ready out 1: source stream in.
  - ds_data out 64 / ds_last out 1 / ds_valid out 1 / ds_ready in 1: result stream out.
  - m_reset out 1 / m_enable out 1 / dc out 24: engine control.
  - m_src out 64 / m_src_last out 1 / m_src_almost_empty out 1 / m_src_empty out 1 / m_src_getn in 1: engine source FIFO read port.
  - m_dst in 64 / m_dst_last in 1 / m_dst_almost_full out 1 / m_dst_full out 1 / m_dst_putn in 1: engine destination FIFO write port.
  - m_endn in 1: engine end-of-job, active-low.
  - busy out 1 / done out 1 / err_ovf out 1 / err_unf out 1: status.

Function
- REQ-004: The source FIFO SHALL be first-word-fall-through.
  - m_src and m_src_last always show the head entry; their value is don't-care when m_src_empty=1.
- REQ-005: A source pop SHALL occur on any rising edge with m_src_getn=0 and m_src_empty=0.
  - getn=0 while empty: no pop, err_unf set (sticky).
- REQ-006: A source push SHALL occur when ss_valid=1 and ss_ready=1.
  - ss_ready = (state==RUN) & !src_full & !last_taken.
  - last_taken sets when a word with ss_last=1 is pushed and clears on job accept.
- REQ-007: Simultaneous push and pop SHALL leave the count unchanged.
  - ss_ready is computed from the pre-pop count, so a full FIFO accepts no push in a pop cycle.
- REQ-008: Destination push SHALL occur on any edge with m_dst_putn=0.
  - If m_dst_full=1: word dropped, err_ovf set (sticky).
- REQ-009: ds_valid SHALL equal !dst_empty, with ds_data/ds_last at the head; a pop occurs when ds_valid & ds_ready.
  - Simultaneous push and pop leaves the count unchanged.
- REQ-010: Pointers SHALL wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
  - Flags are registered from the next-state count, so there is no extra cycle of lag.
- REQ-011: FSM states SHALL be IDLE, RST, RUN, DRAIN, DONE.
- REQ-012: IDLE: job_ready=1. job_valid=1 SHALL latch job_dc into dc, clear both FIFOs, clear err_ovf/err_unf and last_taken, and go to RST.
- REQ-013: RST SHALL hold m_reset=1 and m_enable=0 for exactly 2 cycles, then go to RUN.
- REQ-014: RUN SHALL hold m_enable=1; a sampled m_endn=0 goes to DRAIN next cycle and m_enable drops to 0 in that cycle.
- REQ-015: DRAIN SHALL ignore m_src_getn (no pops, no err_unf) and accept m_dst_putn normally.
  - Goes to DONE when dst_empty=1 and no push occurs that cycle.
- REQ-016: DONE SHALL last 1 cycle with done=1 (single-cycle pulse), then return to IDLE.
- REQ-017: busy SHALL be 1 in RST, RUN and DRAIN, and 0 in IDLE and DONE.
- REQ-018: dc SHALL stay stable from the job-accept edge until the next job accept.
- REQ-019: Source words left unconsumed at the end of a job SHALL be discarded by the next job's clear.
- REQ-020: m_endn=0 seen outside RUN SHALL be ignored.

Reset
- REQ-021: wb_rst_i=1 SHALL, on the next edge, set state IDLE, zero both FIFO pointers and counts, and zero dc, last_taken, err_ovf and err_unf.
- REQ-022: During and after reset, outputs SHALL be: m_enable=0, busy=0, done=0, ss_ready=0, ds_valid=0, m_src_empty=1, m_src_almost_empty=1, m_dst_full=0, m_dst_almost_full=0.
- REQ-023: m_reset SHALL equal wb_rst_i | (state==RST), so the engine is held in reset throughout system reset.
- REQ-024: Reset asserted mid-job SHALL abort the job with no done pulse; buffered data is lost.

Verification
- REQ-025: Nominal job.
  - Stimulus: job_dc=24'h000010, 4 source words, last on word 4; engine pops all 4, pushes 1 word with last, then m_endn=0.
  - Required: m_reset high 2 cycles; m_enable high until the cycle after m_endn; ds_valid for 1 word with ds_last=1; done pulses once; busy falls with done.
- REQ-026: Source full with DEPTH=16 and no pops.
  - Stimulus: 20 source words offered.
  - Required: exactly 16 accepted; ss_ready=0 from the 16th push on; m_src_almost_empty=0 at count 3.
  - Then one getn=0 while ss_valid=1: count stays 16 that cycle, and the next cycle accepts a push.
- REQ-027: Underflow.
  - Stimulus: m_src_getn=0 for 2 cycles with an empty source FIFO in RUN.
  - Required: err_unf=1, count stays 0, m_src_empty stays 1.
- REQ-028: Overflow.
  - Stimulus: ds_ready=0, engine pushes 17 words.
  - Required: 16 stored, m_dst_full=1 after the 16th, err_ovf=1, m_dst_almost_full=1 at 14 stored.
  - After m_endn=0: state DRAIN until ds_ready drains all 16 words, then done.
- REQ-029: Reset mid-job.
  - Stimulus: wb_rst_i for 1 cycle during RUN with 5 words buffered.
  - Required: next cycle IDLE, m_enable=0, m_reset=1 during reset, m_src_empty=1, no done pulse, job_ready=1 afterwards.
